// File: rtl/fc_pkg.sv
// Shared types and helpers for the redundancy voter / fault controller.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    VOTE,
    DONE
  } state_t;

  localparam int MODE_MAJ = 0;
  localparam int MODE_DET = 1;

  function automatic int maj_thresh(input int n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/fc_word_vote.sv
// Combinational word-level vote over the captured replica words.
module fc_word_vote
  import fc_pkg::*;
#(
  parameter int N     = 3,
  parameter int WIDTH = 40,
  parameter int MODE  = MODE_MAJ
) (
  input  logic [N*WIDTH-1:0] words,
  input  logic [N-1:0]       valid,
  output logic [WIDTH-1:0]   voted,
  output logic               agree,
  output logic [N-1:0]       mismatch
);

  localparam int TH = maj_thresh(N);

  logic [WIDTH-1:0] w [N];

  for (genvar i = 0; i < N; i++) begin : g_split
    assign w[i] = words[i*WIDTH +: WIDTH];
    assign mismatch[i] = !valid[i] || (w[i] != voted);
  end

  // Bitwise majority equals the majority word whenever one exists.
  always_comb begin : bit_maj
    int ones;
    voted = '0;
    for (int b = 0; b < WIDTH; b++) begin
      ones = 0;
      for (int i = 0; i < N; i++)
        ones += int'(w[i][b] & valid[i]);
      voted[b] = (ones >= TH);
    end
  end

  always_comb begin : word_agree
    int   eq;
    logic hit;
    logic same;
    hit  = 1'b0;
    same = &valid;
    for (int i = 0; i < N; i++) begin
      eq = 0;
      for (int j = 0; j < N; j++)
        eq += int'(valid[i] && valid[j] &&
                   (w[i] == w[j]));
      if (eq >= TH) hit = 1'b1;
      if (w[i] != w[0]) same = 1'b0;
    end
    agree = (MODE == MODE_DET) ? (hit && same)
                               : hit;
  end

endmodule

// File: rtl/fault_vote_ctrl.sv
// N-way replica capture, timeout, vote and fault lockout controller.
module fault_vote_ctrl
  import fc_pkg::*;
#(
  parameter int N           = 3,
  parameter int W           = 40,
  parameter int TW          = 128,
  parameter int MODE        = 0,
  parameter int TIMEOUT     = 64,
  parameter int LOCK_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N*W-1:0]       rep_data,
  input  logic [N*TW-1:0]      rep_tag,
  input  logic [N-1:0]         rep_ready,
  input  logic [W-1:0]         random_fault_data,
  input  logic [TW-1:0]        random_fault_tag,
  output logic [W-1:0]         data_out,
  output logic [TW-1:0]        tag_out,
  output logic                 out_valid,
  output logic                 fault_detect,
  output logic                 uncorrectable,
  output logic [$clog2(LOCK_THRESH+1)-1:0] fault_count,
  output logic                 locked,
  output logic                 busy
);

  localparam int CW = $clog2(TIMEOUT);
  localparam int FW = $clog2(LOCK_THRESH + 1);

  state_t state, state_nx;

  logic [N-1:0]    captured, fresh, cap_nx;
  logic [N*W-1:0]  cap_data;
  logic [N*TW-1:0] cap_tag;
  logic            skew;
  logic [CW-1:0]   cnt;
  logic            timeout_hit;

  logic [W-1:0]    data_q, data_v;
  logic [TW-1:0]   tag_q, tag_v;
  logic            data_ok, tag_ok;
  logic [N-1:0]    data_mm, tag_mm;

  assign fresh = (state == COLLECT)
               ? (rep_ready & ~captured) : '0;
  assign cap_nx = captured | fresh;
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start && !locked) state_nx = COLLECT;
      COLLECT: if (&cap_nx || timeout_hit) state_nx = VOTE;
      VOTE:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    out_valid = (state == DONE) && !locked;
    data_out  = locked ? random_fault_data : data_q;
    tag_out   = locked ? random_fault_tag  : tag_q;
  end

  // Capture state is cleared while idle so each run starts fresh.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) begin
      captured <= '0;
      cap_data <= '0;
      cap_tag  <= '0;
      skew     <= 1'b0;
      cnt      <= '0;
    end else if (state == COLLECT) begin
      captured <= cap_nx;
      cnt      <= cnt + 1'b1;
      if (fresh != '0 && fresh != ~captured)
        skew <= 1'b1;
      for (int i = 0; i < N; i++) begin
        if (fresh[i]) begin
          cap_data[i*W +: W]   <= rep_data[i*W +: W];
          cap_tag[i*TW +: TW]  <= rep_tag[i*TW +: TW];
        end
      end
    end
  end

  fc_word_vote #(
    .N(N), .WIDTH(W), .MODE(MODE)
  ) u_data_vote (
    .words   (cap_data),
    .valid   (captured),
    .voted   (data_v),
    .agree   (data_ok),
    .mismatch(data_mm)
  );

  fc_word_vote #(
    .N(N), .WIDTH(TW), .MODE(MODE)
  ) u_tag_vote (
    .words   (cap_tag),
    .valid   (captured),
    .voted   (tag_v),
    .agree   (tag_ok),
    .mismatch(tag_mm)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q        <= '0;
      tag_q         <= '0;
      fault_detect  <= 1'b0;
      uncorrectable <= 1'b0;
    end else if (state == VOTE) begin
      if (data_ok && tag_ok) begin
        data_q <= data_v;
        tag_q  <= tag_v;
      end else begin
        data_q <= random_fault_data;
        tag_q  <= random_fault_tag;
      end
      fault_detect  <= skew | (|data_mm) | (|tag_mm);
      uncorrectable <= !(data_ok && tag_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_count <= '0;
      locked      <= 1'b0;
    end else begin
      if (state == DONE && fault_detect &&
          fault_count != FW'(LOCK_THRESH))
        fault_count <= fault_count + 1'b1;
      if (fault_count == FW'(LOCK_THRESH))
        locked <= 1'b1;
    end
  end

endmodule
